// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared definitions for the serial-in/parallel-out deserializer.
//   state_t : frame-collection state (SHIFT collects data beats, PARITY
//             waits for the trailing parity beat when parity is built in).
//   clog2   : ceiling log2, used to size the beat counter.
package sipo_pkg;

  typedef enum logic {
    ST_SHIFT  = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_beat_counter.sv
// sipo_beat_counter -- modulo-N beat counter with synchronous restart.
//   clk, reset_n : clock and asynchronous active-low reset
//   restart      : realign; with en the current beat counts as beat 0
//   en           : one beat accepted this cycle
//   last         : the next accepted beat is beat N-1
module sipo_beat_counter
  import sipo_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  input  logic en,
  output logic last
);

  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(N - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart) begin
      // A beat arriving with restart is beat 0, so the next one is beat 1.
      count <= (en && (N > 1)) ? CNT_W'(1) : '0;
    end else if (en) begin
      count <= (count == TOP) ? '0 : count + CNT_W'(1);
    end
  end

  assign last = (count == TOP);

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in/parallel-out deserializer with ready/valid output.
//   clk, reset_n     : clock, asynchronous active-low reset
//   sin_valid        : serial_in carries a beat (LANES bits, MSB earliest)
//   serial_in        : beat data
//   frame_sync       : restart word alignment, partial word discarded
//   data, data_valid : assembled word and its valid flag (registered)
//   data_ready       : consumer accepts data while data_valid is high
//   overrun          : sticky, a completed word was dropped
//   overrun_clr      : synchronous clear of overrun
//   parity_err       : only with SIPO_DESER_PARITY_EN defined; each frame then
//                      carries an extra even-parity beat after the data beats.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sin_valid,
  input  logic [LANES-1:0]      serial_in,
  input  logic                  frame_sync,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  input  logic                  overrun_clr
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int BEATS    = DATA_WIDTH / LANES;
  localparam bit ONE_BEAT = (BEATS == 1);

  // Concatenate then slice so DATA_WIDTH == LANES needs no special case.
  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] base,
    input logic [LANES-1:0]      beat
  );
    logic [DATA_WIDTH+LANES-1:0] cat;
    if (MSB_FIRST) begin
      cat = {base, beat};
      return cat[DATA_WIDTH-1:0];
    end else begin
      cat = {beat, base};
      return cat[DATA_WIDTH+LANES-1:LANES];
    end
  endfunction

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] next_shift;
  logic [DATA_WIDTH-1:0] word;
  logic                  cnt_last;
  logic                  is_last;
  logic                  data_beat;
  logic                  word_done;
  logic                  load;
  logic                  ovr_event;

  // frame_sync discards the partial word, so the beat shifts into zeros.
  assign next_shift = shift_in(frame_sync ? '0 : shift_reg, serial_in);
  assign is_last    = frame_sync ? ONE_BEAT : cnt_last;

`ifdef SIPO_DESER_PARITY_EN
  state_t state;
  logic   parity_calc;

  // In PARITY the accepted beat is the parity bit, unless frame_sync turns
  // it back into data beat 0.
  assign data_beat   = sin_valid && ((state == ST_SHIFT) || frame_sync);
  assign word_done   = sin_valid && (state == ST_PARITY) && !frame_sync;
  assign word        = shift_reg;
  assign parity_calc = (^shift_reg) ^ serial_in[LANES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_SHIFT;
    end else if (data_beat && is_last) begin
      state <= ST_PARITY;
    end else if (frame_sync || word_done) begin
      state <= ST_SHIFT;
    end
  end
`else
  assign data_beat = sin_valid;
  assign word_done = data_beat && is_last;
  assign word      = next_shift;
`endif

  sipo_beat_counter #(
    .N (BEATS)
  ) u_beat_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (frame_sync),
    .en      (data_beat),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
    end else if (data_beat) begin
      shift_reg <= next_shift;
    end else if (frame_sync) begin
      shift_reg <= '0;
    end
  end

  // A completed word loads when the output slot is empty or being consumed
  // on this same edge; otherwise it is dropped and flagged.
  assign load      = word_done && (!data_valid || data_ready);
  assign ovr_event = word_done && data_valid && !data_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        data       <= word;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (ovr_event) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= parity_calc;
    end
  end
`endif

endmodule
